// File: rtl/cvxif_share_arb.sv
// Shares one CV-X-IF coprocessor between several requesters: a round-robin issue
// arbiter with a one-entry output register, plus tag-based result routing.
module cvxif_share_arb #(
  parameter  int unsigned NrHarts        = 2,
  parameter  int unsigned IdWidth        = 3,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned TagWidth       = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic [NrHarts-1:0]            issue_valid_i,
  output logic [NrHarts-1:0]            issue_ready_o,
  input  logic [NrHarts*IdWidth-1:0]    issue_id_i,
  input  logic [NrHarts*32-1:0]         issue_instr_i,

  output logic                          cop_issue_valid_o,
  input  logic                          cop_issue_ready_i,
  output logic [TagWidth+IdWidth-1:0]   cop_issue_id_o,
  output logic [31:0]                   cop_issue_instr_o,

  input  logic                          cop_result_valid_i,
  output logic                          cop_result_ready_o,
  input  logic [TagWidth+IdWidth-1:0]   cop_result_id_i,
  input  logic [63:0]                   cop_result_data_i,

  output logic [NrHarts-1:0]            result_valid_o,
  input  logic [NrHarts-1:0]            result_ready_i,
  output logic [IdWidth-1:0]            result_id_o,
  output logic [63:0]                   result_data_o,

  output logic                          tag_err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned TidWidth = TagWidth + IdWidth;

  logic                              issue_valid_q, issue_valid_d;
  logic [TidWidth-1:0]               issue_id_q, issue_id_d;
  logic [31:0]                       issue_instr_q, issue_instr_d;
  logic [TagWidth-1:0]               rr_q, rr_d;
  logic [NrHarts-1:0][CntWidth-1:0]  cnt_q, cnt_d;
  logic                              tag_err_q, tag_err_d;

  logic                              reg_free;
  logic [NrHarts-1:0]                eligible;
  logic                              grant_found;
  logic [TagWidth-1:0]               grant_idx;
  logic                              accept;
  logic [IdWidth-1:0]                sel_id;
  logic [31:0]                       sel_instr;

  logic [TagWidth-1:0]               res_tag;
  logic                              res_routed;
  logic [NrHarts-1:0]                res_hs;

  assign reg_free = !issue_valid_q || cop_issue_ready_i;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NrHarts; k++) begin
      eligible[k] = issue_valid_i[k] && (cnt_q[k] < CntWidth'(MaxOutstanding));
    end
  end

  // Two passes implement "first eligible at or after rr_q, then wrap to 0".
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NrHarts; k++) begin
      if (!grant_found && eligible[k] && (TagWidth'(k) >= rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = TagWidth'(k);
      end
    end
    for (int k = 0; k < NrHarts; k++) begin
      if (!grant_found && eligible[k] && (TagWidth'(k) < rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = TagWidth'(k);
      end
    end
  end

  assign accept = rst_ni && reg_free && grant_found;

  always_comb begin
    issue_ready_o = '0;
    sel_id        = '0;
    sel_instr     = '0;
    for (int k = 0; k < NrHarts; k++) begin
      if (grant_idx == TagWidth'(k)) begin
        issue_ready_o[k] = accept;
        sel_id           = issue_id_i[k*IdWidth +: IdWidth];
        sel_instr        = issue_instr_i[k*32 +: 32];
      end
    end
  end

  // Drain and reload may coincide, which keeps one issue per cycle flowing.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_id_d    = issue_id_q;
    issue_instr_d = issue_instr_q;
    if (cop_issue_ready_i) begin
      issue_valid_d = 1'b0;
    end
    if (accept) begin
      issue_valid_d = 1'b1;
      issue_id_d    = {grant_idx, sel_id};
      issue_instr_d = sel_instr;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (grant_idx == TagWidth'(NrHarts - 1)) ? '0 : grant_idx + TagWidth'(1);
    end
  end

  assign res_tag = cop_result_id_i[IdWidth +: TagWidth];

  // A result is routed only to an existing requester that has something outstanding;
  // anything else is swallowed so the coprocessor never stalls on a bad tag.
  always_comb begin
    res_routed         = 1'b0;
    cop_result_ready_o = 1'b1;
    result_valid_o     = '0;
    res_hs             = '0;
    for (int k = 0; k < NrHarts; k++) begin
      if ((res_tag == TagWidth'(k)) && (cnt_q[k] != '0)) begin
        res_routed         = 1'b1;
        cop_result_ready_o = result_ready_i[k];
        result_valid_o[k]  = cop_result_valid_i;
        res_hs[k]          = cop_result_valid_i && result_ready_i[k];
      end
    end
  end

  assign tag_err_d = tag_err_q || (cop_result_valid_i && !res_routed);

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NrHarts; k++) begin
      if (accept && (grant_idx == TagWidth'(k)) && !res_hs[k]) begin
        cnt_d[k] = cnt_q[k] + CntWidth'(1);
      end else if (res_hs[k] && !(accept && (grant_idx == TagWidth'(k)))) begin
        cnt_d[k] = cnt_q[k] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      issue_instr_q <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      issue_instr_q <= issue_instr_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      tag_err_q     <= tag_err_d;
    end
  end

  assign cop_issue_valid_o = issue_valid_q;
  assign cop_issue_id_o    = issue_id_q;
  assign cop_issue_instr_o = issue_instr_q;
  assign result_id_o       = cop_result_id_i[IdWidth-1:0];
  assign result_data_o     = cop_result_data_i;
  assign tag_err_o         = tag_err_q;

endmodule

// File: tb/tb_cvxif_share_arb.sv
// Randomized scoreboard bench for cvxif_share_arb with three requesters, so that
// an out-of-range tag (3) can be presented on the result path.
module tb_cvxif_share_arb;

   localparam int N    = 3;
   localparam int IDW  = 3;
   localparam int MAXO = 4;
   localparam int TW   = 2;

   logic                clk;
   logic                rstN;
   logic [N-1:0]        issueValid;
   logic [N-1:0]        issueReady;
   logic [N*IDW-1:0]    issueId;
   logic [N*32-1:0]     issueInstr;
   logic                copIssueValid;
   logic                copIssueReady;
   logic [TW+IDW-1:0]   copIssueId;
   logic [31:0]         copIssueInstr;
   logic                copResultValid;
   logic                copResultReady;
   logic [TW+IDW-1:0]   copResultId;
   logic [63:0]         copResultData;
   logic [N-1:0]        resultValid;
   logic [N-1:0]        resultReady;
   logic [IDW-1:0]      resultId;
   logic [63:0]         resultData;
   logic                tagErr;

   typedef struct {
      int               tag;
      logic [IDW-1:0]   id;
      logic [31:0]      instr;
   } issueT;

   typedef struct {
      int               tag;
      logic [IDW-1:0]   id;
      logic [63:0]      data;
   } resultT;

   issueT   issueQ[$];
   resultT  resQ[$];

   int errCount   = 0;
   int checkCount = 0;

   // Reference model state: what each requester has in flight, whose turn it is,
   // whether the coprocessor-facing slot is occupied, and the sticky error flag.
   int mCnt[N];
   int mRr;
   bit mRegValid;
   bit mTagErr;

   // Decisions taken when stimulus is applied, committed after the outputs are checked.
   bit          inReset;
   bit          acceptFlag;
   int          grantK;
   bit          decFlag;
   bit          dropFlag;
   int          resTag;
   logic [N-1:0] expIssueReady;
   logic [N-1:0] expResValid;
   logic        expCopResReady;

   cvxif_share_arb #(
      .NrHarts(N),
      .IdWidth(IDW),
      .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk),
      .rst_ni(rstN),
      .issue_valid_i(issueValid),
      .issue_ready_o(issueReady),
      .issue_id_i(issueId),
      .issue_instr_i(issueInstr),
      .cop_issue_valid_o(copIssueValid),
      .cop_issue_ready_i(copIssueReady),
      .cop_issue_id_o(copIssueId),
      .cop_issue_instr_o(copIssueInstr),
      .cop_result_valid_i(copResultValid),
      .cop_result_ready_o(copResultReady),
      .cop_result_id_i(copResultId),
      .cop_result_data_i(copResultData),
      .result_valid_o(resultValid),
      .result_ready_i(resultReady),
      .result_id_o(resultId),
      .result_data_o(resultData),
      .tag_err_o(tagErr)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check funnels through here so the counters stay honest.
   task automatic checkEq(input string name, input logic [127:0] act, input logic [127:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Randomize all inputs for this cycle and work out, from the model, what the design
   // must do with them; expected transfers go straight into the scoreboard queues.
   task automatic applyStimulus(input bit forceReset, input int resultRate);
      bit free;
      bit found;
      bit routed;
      int k;
      int start;
      logic [IDW-1:0] rid;
      rstN = forceReset ? 1'b0 : ($urandom_range(0, 199) != 0);
      for (int j = 0; j < N; j++) begin
         issueValid[j]             = ($urandom_range(0, 9) < 6);
         issueId[j*IDW +: IDW]     = IDW'($urandom);
         issueInstr[j*32 +: 32]    = $urandom;
      end
      copIssueReady  = ($urandom_range(0, 9) < 7);
      resultReady    = N'($urandom_range(0, (1 << N) - 1));
      copResultValid = ($urandom_range(0, 99) < resultRate);
      if ($urandom_range(0, 9) < 8) begin
         start  = $urandom_range(0, N - 1);
         resTag = start;
         found  = 1'b0;
         for (int i = 0; i < N; i++) begin
            k = (start + i) % N;
            if (!found && mCnt[k] > 0) begin
               found  = 1'b1;
               resTag = k;
            end
         end
      end else begin
         resTag = $urandom_range(0, (1 << TW) - 1);
      end
      rid           = IDW'($urandom);
      copResultId   = {TW'(resTag), rid};
      copResultData = {$urandom, $urandom};

      inReset        = !rstN;
      acceptFlag     = 1'b0;
      decFlag        = 1'b0;
      dropFlag       = 1'b0;
      grantK         = 0;
      expIssueReady  = '0;
      expResValid    = '0;
      expCopResReady = 1'b1;
      if (rstN) begin
         free  = !mRegValid || copIssueReady;
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            k = (mRr + i) % N;
            if (!found && issueValid[k] && mCnt[k] < MAXO) begin
               found  = 1'b1;
               grantK = k;
            end
         end
         if (free && found) begin
            acceptFlag            = 1'b1;
            expIssueReady[grantK] = 1'b1;
            issueQ.push_back('{grantK, issueId[grantK*IDW +: IDW], issueInstr[grantK*32 +: 32]});
         end
         routed = (resTag < N) && (mCnt[resTag] > 0);
         if (routed) begin
            expCopResReady = resultReady[resTag];
            if (copResultValid) begin
               expResValid[resTag] = 1'b1;
               if (resultReady[resTag]) begin
                  decFlag = 1'b1;
                  resQ.push_back('{resTag, rid, copResultData});
               end
            end
         end else if (copResultValid) begin
            dropFlag = 1'b1;
         end
      end
   endtask

   // Compare the combinational and registered outputs for this cycle, then advance the model
   // to what the next clock edge should leave behind.
   task automatic checkOutput();
      if (inReset) begin
         checkEq("reset_issue_ready", 128'(issueReady), 128'(0));
         for (int j = 0; j < N; j++) mCnt[j] = 0;
         mRr       = 0;
         mRegValid = 1'b0;
         mTagErr   = 1'b0;
         issueQ.delete();
      end else begin
         checkEq("issue_ready",      128'(issueReady),     128'(expIssueReady));
         checkEq("cop_issue_valid",  128'(copIssueValid),  128'(mRegValid));
         checkEq("result_valid",     128'(resultValid),    128'(expResValid));
         checkEq("cop_result_ready", 128'(copResultReady), 128'(expCopResReady));
         checkEq("tag_err",          128'(tagErr),         128'(mTagErr));
         checkEq("result_id_bus",    128'(resultId),       128'(copResultId[IDW-1:0]));
         checkEq("result_data_bus",  128'(resultData),     128'(copResultData));
         if (acceptFlag) begin
            mCnt[grantK]++;
            mRr       = (grantK + 1) % N;
            mRegValid = 1'b1;
         end else if (copIssueReady) begin
            mRegValid = 1'b0;
         end
         if (decFlag) mCnt[resTag]--;
         if (dropFlag) mTagErr = 1'b1;
      end
   endtask

   // Monitor: whenever the design presents an issue or completes a result handshake,
   // match it against the oldest expected entry. A held issue is compared every cycle.
   always @(negedge clk) begin
      if (rstN === 1'b1) begin
         if (copIssueValid) begin
            if (issueQ.size() == 0) begin
               checkEq("issue_unexpected", 128'(copIssueValid), 128'(0));
            end else begin
               checkEq("cop_issue_id",    128'(copIssueId),    128'({TW'(issueQ[0].tag), issueQ[0].id}));
               checkEq("cop_issue_instr", 128'(copIssueInstr), 128'(issueQ[0].instr));
               if (copIssueReady) void'(issueQ.pop_front());
            end
         end
         for (int j = 0; j < N; j++) begin
            if (resultValid[j] && resultReady[j]) begin
               if (resQ.size() == 0) begin
                  checkEq("result_unexpected", 128'(j), 128'(N));
               end else begin
                  checkEq("result_tag",  128'(j),          128'(resQ[0].tag));
                  checkEq("result_id",   128'(resultId),   128'(resQ[0].id));
                  checkEq("result_data", 128'(resultData), 128'(resQ[0].data));
                  void'(resQ.pop_front());
               end
            end
         end
      end
   end

   // Main sequence: hold reset briefly, then run a back-pressured phase where results are
   // scarce (counters saturate) followed by a phase with frequent results and bad tags.
   initial begin
      rstN           = 1'b0;
      issueValid     = '0;
      issueId        = '0;
      issueInstr     = '0;
      copIssueReady  = 1'b0;
      copResultValid = 1'b0;
      copResultId    = '0;
      copResultData  = '0;
      resultReady    = '0;
      for (int j = 0; j < N; j++) mCnt[j] = 0;
      mRr       = 0;
      mRegValid = 1'b0;
      mTagErr   = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         applyStimulus(c < 3, (c < 1500) ? 8 : 45);
         @(negedge clk);
         checkOutput();
      end
      @(posedge clk);
      #1;
      checkEq("result_queue_drained", 128'(resQ.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
